// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory and hands
// captured words to the decoder through a valid/ready IF/ID register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] PC_LIMIT = 32'd104
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic slot_free;
  logic target_aligned;
  logic capture;
  logic flush;
  logic load_pc;
  logic set_misaligned;

  assign slot_free      = !if_valid || if_ready;
  assign target_aligned = (redirect_target[1:0] == 2'b00);
  assign halted         = (state_q == HALT);

  // Redirects outrank both capture and the end-of-program halt; BOOT ignores
  // everything so the memory load window is never disturbed.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned and infers a latch.
    state_d        = state_q;
    capture        = 1'b0;
    flush          = 1'b0;
    load_pc        = 1'b0;
    set_misaligned = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH, HALT: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (target_aligned) begin
            load_pc = 1'b1;
            state_d = FETCH;
          end else begin
            set_misaligned = 1'b1;
            state_d        = HALT;
          end
        end else if (state_q == FETCH && slot_free) begin
          if (pc < PC_LIMIT) begin
            capture = 1'b1;
          end else begin
            flush   = 1'b1;
            state_d = HALT;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= 32'h0;
      if_pc      <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      state_q <= state_d;

      if (load_pc) begin
        pc <= redirect_target;
      end else if (capture) begin
        pc <= pc + PC_STEP;
      end

      if (flush) begin
        if_valid <= 1'b0;
      end else if (capture) begin
        if_valid <= 1'b1;
      end else if (if_ready) begin
        if_valid <= 1'b0;
      end

      // Payload only moves on capture, so it is frozen while the decoder stalls.
      if (capture) begin
        if_instr <= instruction_code;
        if_pc    <= pc;
      end

      if (set_misaligned) begin
        misaligned <= 1'b1;
      end
    end
  end

endmodule
